// File: rtl/twoone_mux_arbiter.sv
// twoone_mux_arbiter: round-robin arbiter for a shared 2:1 mux with a registered valid/ready output stage (optional ARB_LOCK_EN back-to-back ownership)
module twoone_mux_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_req,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_lock,
    output logic             a_ack,
    input  logic             b_req,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_lock,
    output logic             b_ack,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, SRV_A, SRV_B} state_t;
    state_t state, state_nxt;
    logic last_grant, last_nxt, valid_nxt, a_ack_nxt, b_ack_nxt, sel_nxt;
    logic [WIDTH-1:0] data_nxt;
    logic hs, grant_a, grant_b, relock_a, relock_b;
    assign hs = out_valid & out_ready;
    assign grant_a = a_req & (~b_req | last_grant);
    assign grant_b = b_req & ~grant_a;
    assign busy = state != IDLE;
`ifdef ARB_LOCK_EN
    assign relock_a = a_lock & a_req;
    assign relock_b = b_lock & b_req;
`else
    logic unused_lock;
    assign unused_lock = a_lock ^ b_lock;
    assign relock_a = 1'b0;
    assign relock_b = 1'b0;
`endif
    // next-state and registered-output values
    always_comb begin
        state_nxt = state;
        valid_nxt = out_valid;
        data_nxt = out_data;
        a_ack_nxt = 1'b0;
        b_ack_nxt = 1'b0;
        sel_nxt = sel;
        last_nxt = last_grant;
        case (state)
            IDLE: begin
                if (grant_a) begin
                    state_nxt = SRV_A;
                    valid_nxt = 1'b1;
                    data_nxt = a_data;
                    a_ack_nxt = 1'b1;
                    sel_nxt = 1'b0;
                end else if (grant_b) begin
                    state_nxt = SRV_B;
                    valid_nxt = 1'b1;
                    data_nxt = b_data;
                    b_ack_nxt = 1'b1;
                    sel_nxt = 1'b1;
                end
            end
            SRV_A: begin
                if (hs && relock_a) begin
                    data_nxt = a_data;
                    a_ack_nxt = 1'b1;
                end else if (hs) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    last_nxt = 1'b0;
                end
            end
            SRV_B: begin
                if (hs && relock_b) begin
                    data_nxt = b_data;
                    b_ack_nxt = 1'b1;
                end else if (hs) begin
                    state_nxt = IDLE;
                    valid_nxt = 1'b0;
                    last_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
    // state and output registers; last_grant resets to B so A wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            out_valid <= 1'b0;
            out_data <= '0;
            a_ack <= 1'b0;
            b_ack <= 1'b0;
            sel <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            state <= state_nxt;
            out_valid <= valid_nxt;
            out_data <= data_nxt;
            a_ack <= a_ack_nxt;
            b_ack <= b_ack_nxt;
            sel <= sel_nxt;
            last_grant <= last_nxt;
        end
    end
endmodule
